// File: rtl/ddr_arb_pkg.sv
// Shared types and helpers for the DDR channel arbiters (ddr_wr_arb, later ddr_rd_arb).
// Contents: FSM state enum, DDR response codes, statistics widths, one-hot to index helper.
package ddr_arb_pkg;

  localparam int unsigned MAX_REQ      = 4;
  localparam int unsigned IDX_W        = 2;
  localparam int unsigned RESP_W       = 2;
  localparam int unsigned STAT_BURST_W = 16;
  localparam int unsigned STAT_ERR_W   = 8;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  // Index of the set bit of a one-hot vector (0 when no bit is set).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ddr_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
// Ports:
//   valid  in  NUM_REQ  request vector
//   ptr    in  PTR_W    highest-priority requester index
//   gnt_c  out NUM_REQ  one-hot pick (all zero when no valid)
module ddr_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_c
);

  int unsigned j;
  logic        found;

  // Scan requesters starting at ptr; first hit wins.
  always_comb begin
    gnt_c = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr) + k) % NUM_REQ;
      if (!found && valid[PTR_W'(j)]) begin
        gnt_c[PTR_W'(j)] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_wr_arb.sv
// Round-robin arbiter sharing the single DDR write channel among NUM_REQ requesters.
// One requester owns the channel for a whole burst (request, data, response), then
// the channel is re-arbitrated. Output muxing is combinational from registered state/grant.
// Ports:
//   clk, rstn                         clock, synchronous active-low reset
//   req_wreq_* / req_wdata_* / req_wresp*   per-requester side (flattened vectors)
//   ddr_wreq_* / ddr_wdata_* / ddr_wresp*   single DDR write engine side
//   busy                              high whenever a burst is in flight
// Build option DDR_WR_ARB_STAT_EN: adds stat_burst_cnt (per-requester completed bursts)
// and stat_err_cnt (bursts answered with a non-OKAY response), both saturating.
module ddr_wr_arb
  import ddr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SIZE_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             req_wreq_valid,
  output logic [NUM_REQ-1:0]             req_wreq_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_wreq_addr,
  input  logic [NUM_REQ*SIZE_WIDTH-1:0]  req_wreq_size,
  input  logic [NUM_REQ-1:0]             req_wdata_valid,
  output logic [NUM_REQ-1:0]             req_wdata_ready,
  input  logic [NUM_REQ-1:0]             req_wdata_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_wresp_valid,
  output logic [RESP_W-1:0]              req_wresp,
  input  logic                           ddr_wreq_ready,
  output logic                           ddr_wreq_valid,
  output logic [ADDR_WIDTH-1:0]          ddr_wreq_addr,
  output logic [SIZE_WIDTH-1:0]          ddr_wreq_size,
  input  logic                           ddr_wdata_ready,
  output logic                           ddr_wdata_valid,
  output logic                           ddr_wdata_last,
  output logic [DATA_WIDTH-1:0]          ddr_wdata,
  input  logic                           ddr_wresp_valid,
  input  logic [RESP_W-1:0]              ddr_wresp,
  output logic                           busy
`ifdef DDR_WR_ARB_STAT_EN
  ,
  output logic [NUM_REQ*STAT_BURST_W-1:0] stat_burst_cnt,
  output logic [STAT_ERR_W-1:0]           stat_err_cnt
`endif
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e           state, state_nxt;
  logic [NUM_REQ-1:0]   gnt, gnt_nxt, pick_c;
  logic [PTR_W-1:0]     ptr, ptr_nxt, ptr_inc;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 resp_done;

  logic                  sel_wreq_valid;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [SIZE_WIDTH-1:0] sel_size;
  logic                  sel_wdata_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  ddr_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .valid (req_wreq_valid),
    .ptr   (ptr),
    .gnt_c (pick_c)
  );

  // Pointer moves to the requester just after the one finishing its burst.
  assign gnt_idx = onehot_to_idx(MAX_REQ'(gnt));
  assign ptr_inc = (32'(gnt_idx) + 32'd1 >= NUM_REQ) ? '0 : PTR_W'(32'(gnt_idx) + 32'd1);

  // Select the granted requester's channel signals (AND-OR mux, gnt is one-hot).
  always_comb begin
    sel_wreq_valid  = 1'b0;
    sel_addr        = '0;
    sel_size        = '0;
    sel_wdata_valid = 1'b0;
    sel_last        = 1'b0;
    sel_data        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_wreq_valid  = req_wreq_valid[i];
        sel_addr        = req_wreq_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_size        = req_wreq_size[i*SIZE_WIDTH +: SIZE_WIDTH];
        sel_wdata_valid = req_wdata_valid[i];
        sel_last        = req_wdata_last[i];
        sel_data        = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State, grant and pointer registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state logic and phase-gated channel routing.
  always_comb begin
    state_nxt       = state;
    gnt_nxt         = gnt;
    ptr_nxt         = ptr;
    resp_done       = 1'b0;
    ddr_wreq_valid  = 1'b0;
    ddr_wreq_addr   = '0;
    ddr_wreq_size   = '0;
    req_wreq_ready  = '0;
    ddr_wdata_valid = 1'b0;
    ddr_wdata_last  = 1'b0;
    ddr_wdata       = '0;
    req_wdata_ready = '0;
    req_wresp_valid = '0;
    req_wresp       = RESP_OKAY;
    case (state)
      ST_IDLE: begin
        if (|req_wreq_valid) begin
          gnt_nxt   = pick_c;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        ddr_wreq_valid = sel_wreq_valid;
        ddr_wreq_addr  = sel_addr;
        ddr_wreq_size  = sel_size;
        req_wreq_ready = gnt & {NUM_REQ{ddr_wreq_ready}};
        if (sel_wreq_valid && ddr_wreq_ready) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        ddr_wdata_valid = sel_wdata_valid;
        ddr_wdata_last  = sel_last;
        ddr_wdata       = sel_data;
        req_wdata_ready = gnt & {NUM_REQ{ddr_wdata_ready}};
        // The size field is not tracked; only the last flag closes the burst.
        if (sel_wdata_valid && ddr_wdata_ready && sel_last) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (ddr_wresp_valid) begin
          resp_done       = 1'b1;
          req_wresp_valid = gnt;
          req_wresp       = ddr_wresp;
          ptr_nxt         = ptr_inc;
          gnt_nxt         = '0;
          state_nxt       = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

`ifdef DDR_WR_ARB_STAT_EN
  logic [STAT_BURST_W-1:0] burst_cnt [NUM_REQ];
  logic [STAT_ERR_W-1:0]   err_cnt;

  // Saturating burst/error counters, updated when a response closes a burst.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) burst_cnt[i] <= '0;
      err_cnt <= '0;
    end else if (resp_done) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && (burst_cnt[i] != '1)) burst_cnt[i] <= burst_cnt[i] + STAT_BURST_W'(1);
      end
      if ((ddr_wresp != RESP_OKAY) && (err_cnt != '1)) err_cnt <= err_cnt + STAT_ERR_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_burst_cnt[g*STAT_BURST_W +: STAT_BURST_W] = burst_cnt[g];
  end
  assign stat_err_cnt = err_cnt;
`endif

endmodule
